// File: rtl/axis_vec_pkg.sv
// Shared types and defaults for the AXI4-Stream vector streamer.
// Imported by the storage RAM and the streamer top level.
package axis_vec_pkg;

   localparam int VEC_DEPTH  = 20;
   localparam int VEC_DATA_W = 32;
   localparam int STALL_W    = 16;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      DONE
   } state_t;

endpackage

// File: rtl/vec_store_ram.sv
// Simple dual-port vector storage: one write port, one synchronous read port.
// The read register holds its value while rd_en is low.
module vec_store_ram
   import axis_vec_pkg::*;
#(
   parameter int DEPTH  = VEC_DEPTH,
   parameter int DATA_W = VEC_DATA_W,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/axis_vec_streamer.sv
// Plays a stored FP32 vector out as an AXI4-Stream with TLAST.
// The RAM read register runs one word ahead of TDATA so beats need no bubble.
module axis_vec_streamer
   import axis_vec_pkg::*;
#(
   parameter int DEPTH  = VEC_DEPTH,
   parameter int DATA_W = VEC_DATA_W,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic               aclk,
   input  logic               rst,
   input  logic               cfg_wr_en,
   input  logic [ADDR_W-1:0]  cfg_wr_addr,
   input  logic [DATA_W-1:0]  cfg_wr_data,
   input  logic [ADDR_W:0]    len,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [STALL_W-1:0] stall_cycles,
   output logic [DATA_W-1:0]  OUTPUT_AXIS_TDATA,
   output logic               OUTPUT_AXIS_TLAST,
   output logic               OUTPUT_AXIS_TVALID,
   input  logic               OUTPUT_AXIS_TREADY
);

   localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

   state_t            state;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   idx;
   logic [ADDR_W:0]   rd_ptr;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic              wr_ok;
   logic              len_ok;
   logic              ptr_ok;
   logic              hs;

   assign len_ok = (len != '0) && (len <= LEN_MAX);
   assign wr_ok  = cfg_wr_en && !busy && ({1'b0, cfg_wr_addr} < LEN_MAX);
   assign ptr_ok = rd_ptr < LEN_MAX;
   assign hs     = OUTPUT_AXIS_TVALID && OUTPUT_AXIS_TREADY;

   // Only advance the read register when the presented word is consumed.
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = rd_ptr[ADDR_W-1:0];
      unique case (state)
         IDLE: begin
            rd_en   = start && len_ok;
            rd_addr = '0;
         end
         FETCH:   rd_en = ptr_ok;
         SEND:    rd_en = hs && !OUTPUT_AXIS_TLAST && ptr_ok;
         default: rd_en = 1'b0;
      endcase
   end

   vec_store_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (aclk),
      .wr_en   (wr_ok),
      .wr_addr (cfg_wr_addr),
      .wr_data (cfg_wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge aclk) begin
      if (rst) begin
         state              <= IDLE;
         busy               <= 1'b0;
         done               <= 1'b0;
         err                <= 1'b0;
         stall_cycles       <= '0;
         OUTPUT_AXIS_TDATA  <= '0;
         OUTPUT_AXIS_TLAST  <= 1'b0;
         OUTPUT_AXIS_TVALID <= 1'b0;
         len_q              <= '0;
         idx                <= '0;
         rd_ptr             <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (OUTPUT_AXIS_TVALID && !OUTPUT_AXIS_TREADY && stall_cycles != '1)
            stall_cycles <= stall_cycles + STALL_W'(1);
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     len_q        <= len;
                     stall_cycles <= '0;
                     rd_ptr       <= ONE;
                     busy         <= 1'b1;
                     state        <= FETCH;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            FETCH: begin
               OUTPUT_AXIS_TDATA  <= rd_data;
               OUTPUT_AXIS_TVALID <= 1'b1;
               OUTPUT_AXIS_TLAST  <= (len_q == ONE);
               idx                <= '0;
               if (ptr_ok) rd_ptr <= rd_ptr + ONE;
               state              <= SEND;
            end
            SEND: begin
               if (hs) begin
                  if (OUTPUT_AXIS_TLAST) begin
                     OUTPUT_AXIS_TVALID <= 1'b0;
                     OUTPUT_AXIS_TLAST  <= 1'b0;
                     done               <= 1'b1;
                     busy               <= 1'b0;
                     state              <= DONE;
                  end else begin
                     OUTPUT_AXIS_TDATA <= rd_data;
                     OUTPUT_AXIS_TLAST <= (idx + ONE + ONE) == len_q;
                     idx               <= idx + ONE;
                     if (ptr_ok) rd_ptr <= rd_ptr + ONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_vec_streamer.sv
// Directed self-checking bench for axis_vec_streamer.
// Beats are captured post-edge and compared with a bench copy of storage.
module tb_axis_vec_streamer;
   import axis_vec_pkg::*;

   localparam int DEPTH  = 20;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              aclk = 1'b0;
   logic              rst;
   logic              cfg_wr_en;
   logic [ADDR_W-1:0] cfg_wr_addr;
   logic [DATA_W-1:0] cfg_wr_data;
   logic [ADDR_W:0]   len;
   logic              start;
   logic              busy;
   logic              done;
   logic              err;
   logic [15:0]       stall_cycles;
   logic [DATA_W-1:0] tdata;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   always #5 aclk = ~aclk;

   axis_vec_streamer #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .aclk               (aclk),
      .rst                (rst),
      .cfg_wr_en          (cfg_wr_en),
      .cfg_wr_addr        (cfg_wr_addr),
      .cfg_wr_data        (cfg_wr_data),
      .len                (len),
      .start              (start),
      .busy               (busy),
      .done               (done),
      .err                (err),
      .stall_cycles       (stall_cycles),
      .OUTPUT_AXIS_TDATA  (tdata),
      .OUTPUT_AXIS_TLAST  (tlast),
      .OUTPUT_AXIS_TVALID (tvalid),
      .OUTPUT_AXIS_TREADY (tready)
   );

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] vec [DEPTH] = '{
      32'h3F7FCDF9, 32'h3E4CCCCD, 32'hBF000000, 32'h3F19999A, 32'h40490FDB,
      32'hBE99999A, 32'h3DCCCCCD, 32'h3F333333, 32'hC0000000, 32'h3F4CCCCD,
      32'h3EB33333, 32'hBF666666, 32'h3F800000, 32'h3C23D70A, 32'hBD4CCCCD,
      32'h3F59999A, 32'h41200000, 32'hBF19999A, 32'h3E000000, 32'hBF7E1200
   };
   logic [31:0] mdl [DEPTH];

   logic [31:0] got   [32];
   logic        lastf [32];
   int nb, lat, stl, done_cyc, last_cyc;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = ADDR_W'(a);
      cfg_wr_data = d;
      tick();
      cfg_wr_en   = 1'b0;
   endtask

   task automatic load_all();
      for (int i = 0; i < DEPTH; i++) begin
         wr(i, vec[i]);
         mdl[i] = vec[i];
      end
   endtask

   // mode 0: TREADY held high; mode 1: TREADY 1,0,1,0 by cycle.
   task automatic run(input int n, input int mode, input bit mid,
                      input int rst_at);
      logic [31:0] hold_d;
      logic        hold_l;
      bit          hold_v;
      bit          rdy;
      bit          rst_pend;
      int          cyc;
      start = 1'b1;
      len   = (ADDR_W+1)'(n);
      tick();
      start = 1'b0;
      cyc = 1; lat = -1; nb = 0; stl = 0;
      done_cyc = -1; last_cyc = -1;
      hold_v = 0; rst_pend = 0;
      chk("busy_on", busy, 1);
      while (cyc < 300) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         rdy = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
         tready = rdy;
         if (mid && cyc == 3) begin
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = 5'd3;
            cfg_wr_data = 32'hDEADBEEF;
            start       = 1'b1;
            len         = 6'd5;
         end
         if (mid && cyc == 4) begin
            cfg_wr_en = 1'b0;
            start     = 1'b0;
         end
         if (tvalid) begin
            if (lat < 0) lat = cyc;
            if (hold_v) begin
               chk("stall_data", tdata, hold_d);
               chk("stall_last", tlast, hold_l);
            end
            if (rdy) begin
               got[nb]   = tdata;
               lastf[nb] = tlast;
               nb++;
               last_cyc  = cyc;
               hold_v    = 0;
               if (rst_at >= 0 && nb == rst_at + 1) rst_pend = 1;
            end else begin
               stl++;
               hold_d = tdata;
               hold_l = tlast;
               hold_v = 1;
            end
         end
         tick();
         cyc++;
         if (rst_pend) begin
            rst    = 1'b1;
            tready = 1'b1;
            tick();
            chk("rst_tvalid", tvalid, 0);
            chk("rst_tlast", tlast, 0);
            chk("rst_busy", busy, 0);
            rst = 1'b0;
            tick();
            return;
         end
      end
      if (done_cyc < 0) chk("timeout", 0, 1);
   endtask

   task automatic verify(input int n, input string tag);
      chk({tag, "_nbeats"}, nb, n);
      chk({tag, "_latency"}, lat, 2);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_data"}, got[i], mdl[i]);
         chk({tag, "_tlast"}, lastf[i], (i == n - 1));
      end
      chk({tag, "_done_at"}, done_cyc, last_cyc + 1);
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_tvalid_at_done"}, tvalid, 0);
      chk({tag, "_stalls"}, stall_cycles, stl);
      tick();
      chk({tag, "_done_pulse"}, done, 0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
      len = '0; start = 1'b0; tready = 1'b0;
      repeat (3) tick();
      chk("rst_busy0", busy, 0);
      chk("rst_done0", done, 0);
      chk("rst_err0", err, 0);
      chk("rst_tvalid0", tvalid, 0);
      chk("rst_tlast0", tlast, 0);
      chk("rst_tdata0", tdata, 0);
      chk("rst_stall0", stall_cycles, 0);
      rst = 1'b0;
      tick();

      load_all();
      run(20, 0, 0, -1);
      verify(20, "full");
      chk("full_no_stall", stall_cycles, 0);

      run(20, 1, 0, -1);
      verify(20, "toggle");

      wr(0, 32'h3F800000);
      mdl[0] = 32'h3F800000;
      run(1, 0, 0, -1);
      verify(1, "len1");
      chk("len1_data", got[0], 32'h3F800000);
      wr(0, vec[0]);
      mdl[0] = vec[0];

      for (int k = 0; k < 2; k++) begin
         start = 1'b1;
         len   = (k == 0) ? 6'd0 : 6'd21;
         tick();
         start = 1'b0;
         chk("bad_err", err, 1);
         chk("bad_busy", busy, 0);
         chk("bad_tvalid", tvalid, 0);
         tick();
         chk("bad_err_pulse", err, 0);
         chk("bad_no_done", done, 0);
         chk("bad_idle_tvalid", tvalid, 0);
      end

      run(20, 0, 1, -1);
      verify(20, "busywr");
      chk("busywr_beat3", got[3], vec[3]);

      wr(3, 32'h12345678);
      mdl[3] = 32'h12345678;
      run(20, 0, 0, -1);
      verify(20, "idlewr");
      chk("idlewr_beat3", got[3], 32'h12345678);

      run(20, 1, 0, 7);
      chk("rst_mid_beats", nb, 8);
      run(20, 0, 0, -1);
      verify(20, "restart");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_vec_streamer.md
Name: axis_vec_streamer

Overview:
- AXI4-Stream master that plays a stored FP32 vector into a stream consumer, such as the dot-product engines (20-element input, 10-element output).
- It is the transmit-side counterpart of the stream input those engines accept, and replaces bench-driven stimulus when the engine is integrated on hardware.
- Software loads words through a simple write port, programs a length, and pulses start.
- The block emits the words in index order with TLAST on the final word, honouring backpressure, and reports done and stall count.

Parameters:
- DEPTH, 20, number of 32-bit storage words (maximum vector length).
- DATA_W, 32, word width (FP32 bit pattern, passed through untouched).
- ADDR_W, $clog2(DEPTH), width of word index and length fields (length field uses ADDR_W+1).

Ports:
- aclk  in  1  clock.
- rst  in  1  reset.
- cfg_wr_en  in  1  write strobe for vector storage.
- cfg_wr_addr  in  ADDR_W  word index to write.
- cfg_wr_data  in  DATA_W  word to store.
- len  in  ADDR_W+1  number of words to send; sampled when start is accepted.
- start  in  1  single-cycle request to begin a transfer.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final handshake.
- err  out  1  one-cycle pulse when start is rejected.
- stall_cycles  out  16  count of cycles in the last transfer where TVALID=1 and TREADY=0.
- OUTPUT_AXIS_TDATA  out  DATA_W  stream data.
- OUTPUT_AXIS_TLAST  out  1  marks the final word.
- OUTPUT_AXIS_TVALID  out  1  stream valid.
- OUTPUT_AXIS_TREADY  in  1  stream ready from the consumer.

Behaviour:
- Interface: one clock (aclk); reset is synchronous and active-high.
- Reset values:
  - busy, done, err, TVALID and TLAST are 0; TDATA is 0; stall_cycles is 0; state is IDLE.
  - Storage contents are not cleared.
- Storage: DEPTH x DATA_W, synchronous-read array (BRAM-inferable).
  - A write lands when cfg_wr_en=1, cfg_wr_addr<DEPTH and busy=0.
  - Writes with an out-of-range address, or while busy=1, are dropped silently.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 with 1<=len<=DEPTH: latch len, clear stall_cycles, issue a read of word 0, set busy=1, go to FETCH.
  - start=1 with len=0 or len>DEPTH: pulse err for one cycle, stay in IDLE; busy and TVALID remain 0.
- FETCH: read data returns; go to SEND.
  - TVALID rises exactly 2 cycles after the start cycle.
- SEND:
  - TVALID=1, TDATA=word[idx], TLAST=(idx==len-1).
  - A handshake is TVALID&TREADY at a rising edge.
  - After a handshake on a non-last word, the next word is presented the following cycle with no bubble. Read lookahead is required: with TREADY held high, len words transfer in len consecutive cycles.
  - TDATA, TLAST and TVALID stay stable while TREADY=0.
  - TVALID never depends combinationally on TREADY.
  - Each cycle with TVALID=1 and TREADY=0 increments stall_cycles, saturating at 16'hFFFF.
  - A handshake on the TLAST word drops TVALID/TLAST the next cycle; go to DONE.
- DONE: pulse done=1 for one cycle, set busy=0, return to IDLE. stall_cycles holds until the next accepted start.
- start while busy=1 is ignored: no err, no effect.
- len changing during a transfer has no effect.
- TREADY high while TVALID=0 is legal and has no effect.
- rst asserted mid-transfer: TVALID, TLAST and busy are 0 on the next cycle; the partial stream is abandoned with no TLAST. A later start resends from word 0.

Decomposition:
- Package axis_vec_pkg: DATA_W/DEPTH defaults, the state enum type (IDLE/FETCH/SEND/DONE), and the stall-counter width constant.
- One natural sub-module, vec_store_ram: a simple dual-port synchronous-read RAM (one write port, one read port). The FSM, lookahead register and counters live in the top level.

Test Plan:
- Load 20 words 0x3F7FCDF9..0xBF7E1200 (the dot_20_10 input vector); len=20; TREADY held 1.
  - TVALID rises 2 cycles after start; 20 consecutive beats in index order.
  - TLAST only on beat 19; done pulses one cycle after beat 19; stall_cycles=0.
- Same load; TREADY toggles 1,0,1,0,...
  - Identical data order; TDATA stable across every stall.
  - 20 beats; stall_cycles = number of TVALID&~TREADY cycles (19 or 20 depending on phase), checked against the bench count.
- len=1, word0=0x3F800000: single beat with TDATA=0x3F800000 and TLAST=1; done one cycle later.
- start with len=0, then with len=21: err pulses each time; TVALID and busy stay 0; no done.
- During busy:
  - cfg_wr_en to address 3 with 0xDEADBEEF: beat 3 still carries the original value.
  - A second start is ignored.
  - A subsequent idle rewrite takes effect on the next run.
- Assert rst after beat 7 is handshaken: TVALID=0 next cycle, busy=0. Release rst, start with len=20: the stream restarts at word 0 and completes with 20 beats.
